// File: rtl/rfdc_nco_reset_sequencer.sv
// rtl/rfdc_nco_reset_sequencer.sv - SYSREF-aligned NCO reset / update sequencer for the RFDC.
// Holds the NCOs in reset for wait+1 SYSREF periods, requests an update, and waits for the ack.
module rfdc_nco_reset_sequencer #(
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_nco_reset,
  input  logic [7:0] sysref_wait_cycles,
  input  logic       sysref_pulse,
  output logic       nco_reset,
  output logic       nco_update_req,
  input  logic       nco_update_ack,
  output logic       nco_reset_done,
  output logic       nco_sync_failed,
  output logic       busy
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] TERM = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ARM      = 3'd1,
    HOLD     = 3'd2,
    UPDATE   = 3'd3,
    WAIT_ACK = 3'd4,
    DONE     = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      wait_q, wait_d;
  logic [7:0]      sp_cnt_q, sp_cnt_d;
  logic [CW-1:0]   to_cnt_q, to_cnt_d;
  logic            nco_reset_q, nco_reset_d;
  logic            upd_req_q, upd_req_d;
  logic            done_q, done_d;
  logic            failed_q, failed_d;

  logic            to_expired;
  logic [CW-1:0]   to_next;

  assign to_expired = (to_cnt_q == TERM);
  assign to_next    = (to_cnt_q == '1) ? to_cnt_q : to_cnt_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    sp_cnt_d    = sp_cnt_q;
    to_cnt_d    = to_cnt_q;
    nco_reset_d = nco_reset_q;
    upd_req_d   = 1'b0;
    done_d      = done_q;
    failed_d    = failed_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (start_nco_reset) begin
          wait_d   = sysref_wait_cycles;
          done_d   = 1'b0;
          failed_d = 1'b0;
          to_cnt_d = '0;
          state_d  = ARM;
        end
      end
      ARM: begin
        if (sysref_pulse) begin
          nco_reset_d = 1'b1;
          sp_cnt_d    = '0;
          to_cnt_d    = '0;
          state_d     = HOLD;
        end else if (to_expired) begin
          nco_reset_d = 1'b0;
          failed_d    = 1'b1;
          done_d      = 1'b1;
          to_cnt_d    = '0;
          state_d     = DONE;
        end else begin
          to_cnt_d = to_next;
        end
      end
      HOLD: begin
        if (sysref_pulse) begin
          to_cnt_d = '0;
          if (sp_cnt_q == wait_q) begin
            nco_reset_d = 1'b0;
            state_d     = UPDATE;
          end else begin
            sp_cnt_d = sp_cnt_q + 8'd1;
          end
        end else if (to_expired) begin
          nco_reset_d = 1'b0;
          failed_d    = 1'b1;
          done_d      = 1'b1;
          to_cnt_d    = '0;
          state_d     = DONE;
        end else begin
          to_cnt_d = to_next;
        end
      end
      UPDATE: begin
        upd_req_d = 1'b1;
        to_cnt_d  = '0;
        state_d   = WAIT_ACK;
      end
      WAIT_ACK: begin
        // An ack landing on the terminal count still counts as success.
        if (nco_update_ack) begin
          done_d   = 1'b1;
          to_cnt_d = '0;
          state_d  = DONE;
        end else if (to_expired) begin
          nco_reset_d = 1'b0;
          failed_d    = 1'b1;
          done_d      = 1'b1;
          to_cnt_d    = '0;
          state_d     = DONE;
        end else begin
          to_cnt_d = to_next;
        end
      end
      default: begin
        nco_reset_d = 1'b0;
        to_cnt_d    = '0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      wait_q      <= '0;
      sp_cnt_q    <= '0;
      to_cnt_q    <= '0;
      nco_reset_q <= 1'b0;
      upd_req_q   <= 1'b0;
      done_q      <= 1'b0;
      failed_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      sp_cnt_q    <= sp_cnt_d;
      to_cnt_q    <= to_cnt_d;
      nco_reset_q <= nco_reset_d;
      upd_req_q   <= upd_req_d;
      done_q      <= done_d;
      failed_q    <= failed_d;
    end
  end

  assign nco_reset       = nco_reset_q;
  assign nco_update_req  = upd_req_q;
  assign nco_reset_done  = done_q;
  assign nco_sync_failed = failed_q;
  assign busy            = (state_q == ARM) || (state_q == HOLD) ||
                           (state_q == UPDATE) || (state_q == WAIT_ACK);

endmodule

// File: tb/tb_rfdc_nco_reset_sequencer.sv
// tb/tb_rfdc_nco_reset_sequencer.sv - self-checking bench for rfdc_nco_reset_sequencer.
// Directed timing scenarios with literal expectations, then randomized traffic against a deadline-based model.
module tb_rfdc_nco_reset_sequencer;

  localparam int T = 100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_nco_reset = 1'b0;
  logic [7:0] sysref_wait_cycles = 8'd0;
  logic       sysref_pulse = 1'b0;
  logic       nco_update_ack = 1'b0;
  logic       nco_reset;
  logic       nco_update_req;
  logic       nco_reset_done;
  logic       nco_sync_failed;
  logic       busy;

  rfdc_nco_reset_sequencer #(.TIMEOUT_CYCLES(T)) dut (
    .clk                (clk),
    .rst                (rst),
    .start_nco_reset    (start_nco_reset),
    .sysref_wait_cycles (sysref_wait_cycles),
    .sysref_pulse       (sysref_pulse),
    .nco_reset          (nco_reset),
    .nco_update_req     (nco_update_req),
    .nco_update_ack     (nco_update_ack),
    .nco_reset_done     (nco_reset_done),
    .nco_sync_failed    (nco_sync_failed),
    .busy               (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: sequence phases tracked by absolute deadlines instead of a cycle counter.
  localparam int PH_QUIET = 0, PH_FIRST = 1, PH_HOLDING = 2, PH_REQUEST = 3, PH_ACK = 4;
  int cyc = 0;
  int m_ph = PH_QUIET;
  int m_latched = 0;
  int m_left = 0;
  int m_deadline = 0;
  bit m_valid = 0;
  bit e_reset = 0, e_req = 0, e_done = 0, e_fail = 0;

  task automatic m_timeout();
    e_reset = 0;
    e_fail  = 1;
    e_done  = 1;
    m_ph    = PH_QUIET;
  endtask

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_ph = PH_QUIET; e_reset = 0; e_req = 0; e_done = 0; e_fail = 0; m_valid = 1;
    end else begin
      e_req = 0;
      case (m_ph)
        PH_QUIET: if (start_nco_reset) begin
          m_latched = int'(sysref_wait_cycles);
          e_done = 0; e_fail = 0;
          m_ph = PH_FIRST; m_deadline = cyc + T;
        end
        PH_FIRST: if (sysref_pulse) begin
          e_reset = 1; m_left = m_latched + 1;
          m_ph = PH_HOLDING; m_deadline = cyc + T;
        end else if (cyc == m_deadline) m_timeout();
        PH_HOLDING: if (sysref_pulse) begin
          m_left--;
          m_deadline = cyc + T;
          if (m_left == 0) begin e_reset = 0; m_ph = PH_REQUEST; end
        end else if (cyc == m_deadline) m_timeout();
        PH_REQUEST: begin
          e_req = 1; m_ph = PH_ACK; m_deadline = cyc + T;
        end
        PH_ACK: if (nco_update_ack) begin
          e_done = 1; m_ph = PH_QUIET;
        end else if (cyc == m_deadline) m_timeout();
        default: m_ph = PH_QUIET;
      endcase
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("nco_reset", int'(nco_reset), int'(e_reset));
      chk("nco_update_req", int'(nco_update_req), int'(e_req));
      chk("nco_reset_done", int'(nco_reset_done), int'(e_done));
      chk("nco_sync_failed", int'(nco_sync_failed), int'(e_fail));
      chk("busy", int'(busy), int'(m_ph != PH_QUIET));
      chk("reset_req_exclusive", int'(nco_reset & nco_update_req), 0);
    end
  end

  int r_rise, r_fall, r_high, r_req_cnt, r_req_at, r_done_at, r_done_rises, r_fail_at;
  int s_reset, s_busy, s_done, s_fail;

  task automatic scen(input int n, input int w, input int w2, input int w_chg,
                      input int sfirst, input int sper, input int ack_t,
                      input int start2_t, input int rst_t, input int snap_t);
    bit p_reset, p_done, p_fail;
    r_rise = -1; r_fall = -1; r_high = 0; r_req_cnt = 0; r_req_at = -1;
    r_done_at = -1; r_done_rises = 0; r_fail_at = -1;
    s_reset = -1; s_busy = -1; s_done = -1; s_fail = -1;
    p_reset = 0; p_done = 0; p_fail = 0;
    for (int t = 0; t < n; t++) begin
      @(negedge clk);
      if (t > 0) begin
        if (nco_reset && !p_reset && r_rise < 0) r_rise = t;
        if (!nco_reset && p_reset && r_fall < 0) r_fall = t;
        if (nco_reset) r_high++;
        if (nco_update_req) begin r_req_cnt++; if (r_req_at < 0) r_req_at = t; end
        if (nco_reset_done && !p_done) begin r_done_rises++; if (r_done_at < 0) r_done_at = t; end
        if (nco_sync_failed && !p_fail && r_fail_at < 0) r_fail_at = t;
      end
      if (t == snap_t) begin
        s_reset = int'(nco_reset); s_busy = int'(busy);
        s_done = int'(nco_reset_done); s_fail = int'(nco_sync_failed);
      end
      p_reset = nco_reset; p_done = nco_reset_done; p_fail = nco_sync_failed;
      start_nco_reset    = (t == 0) || (t == start2_t);
      sysref_wait_cycles = (t >= w_chg) ? 8'(w2) : 8'(w);
      sysref_pulse       = (sper > 0) && (t >= sfirst) && ((t - sfirst) % sper == 0);
      nco_update_ack     = (t == ack_t);
      rst                = (t == rst_t);
    end
    start_nco_reset = 0; sysref_pulse = 0; nco_update_ack = 0; rst = 0;
  endtask

  int sys_div, ack_div;

  initial begin
    rst = 1;
    repeat (3) @(negedge clk);
    chk("reset_nco_reset", int'(nco_reset), 0);
    chk("reset_done", int'(nco_reset_done), 0);
    chk("reset_busy", int'(busy), 0);
    rst = 0;

    // wait=0, SYSREF every 20 from cycle 10, ack at 35
    scen(45, 0, 0, 1000, 10, 20, 35, -1, -1, -1);
    chk("s1_rise", r_rise, 11);
    chk("s1_fall", r_fall, 31);
    chk("s1_high", r_high, 20);
    chk("s1_req_at", r_req_at, 32);
    chk("s1_req_cnt", r_req_cnt, 1);
    chk("s1_done_at", r_done_at, 36);
    chk("s1_failed", int'(nco_sync_failed), 0);

    // wait=3
    scen(120, 3, 3, 1000, 10, 20, 100, -1, -1, -1);
    chk("s2_high", r_high, 80);
    chk("s2_fall", r_fall, 91);
    chk("s2_req_cnt", r_req_cnt, 1);
    chk("s2_req_at", r_req_at, 92);
    chk("s2_done_at", r_done_at, 101);

    // no SYSREF: ARM timeout
    scen(110, 0, 0, 1000, 0, 0, -1, -1, -1, -1);
    chk("s3_fail_at", r_fail_at, 101);
    chk("s3_done_at", r_done_at, 101);
    chk("s3_high", r_high, 0);
    chk("s3_req_cnt", r_req_cnt, 0);

    // no ack: WAIT_ACK timeout; start from failed DONE clears flags
    scen(150, 0, 0, 1000, 10, 20, -1, -1, -1, 1);
    chk("s4_clear_failed", s_fail, 0);
    chk("s4_clear_done", s_done, 0);
    chk("s4_req_cnt", r_req_cnt, 1);
    chk("s4_req_at", r_req_at, 32);
    chk("s4_fail_at", r_fail_at, 132);

    // wait=5 kept despite second start and wait changed to 1
    scen(160, 5, 1, 2, 10, 20, 140, 50, -1, -1);
    chk("s5_high", r_high, 120);
    chk("s5_fall", r_fall, 131);
    chk("s5_req_cnt", r_req_cnt, 1);
    chk("s5_done_at", r_done_at, 141);
    chk("s5_done_rises", r_done_rises, 1);

    // rst during HOLD
    scen(60, 2, 2, 1000, 10, 20, -1, -1, 40, 41);
    chk("s6_high", r_high, 30);
    chk("s6_snap_reset", s_reset, 0);
    chk("s6_snap_busy", s_busy, 0);
    chk("s6_snap_done", s_done, 0);
    chk("s6_snap_fail", s_fail, 0);
    chk("s6_req_cnt", r_req_cnt, 0);

    scen(45, 0, 0, 1000, 10, 20, 35, -1, -1, -1);
    chk("s7_done_at", r_done_at, 36);
    chk("s7_high", r_high, 20);
    chk("s7_failed", int'(nco_sync_failed), 0);

    for (int seg = 0; seg < 12; seg++) begin
      case ($urandom_range(0, 2))
        0: sys_div = 6;
        1: sys_div = 25;
        default: sys_div = 0;
      endcase
      case ($urandom_range(0, 2))
        0: ack_div = 4;
        1: ack_div = 60;
        default: ack_div = 0;
      endcase
      for (int i = 0; i < 300; i++) begin
        @(negedge clk);
        start_nco_reset    = ($urandom_range(0, 19) == 0);
        sysref_wait_cycles = 8'($urandom_range(0, 3));
        sysref_pulse       = (sys_div != 0) && ($urandom_range(0, sys_div - 1) == 0);
        nco_update_ack     = (ack_div != 0) && ($urandom_range(0, ack_div - 1) == 0);
        rst                = ($urandom_range(0, 399) == 0);
      end
    end
    @(negedge clk);
    start_nco_reset = 0; sysref_pulse = 0; nco_update_ack = 0; rst = 0;
    repeat (5) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rfdc_nco_reset_sequencer.md
Name: rfdc_nco_reset_sequencer

Overview:
Sequences the SYSREF-aligned NCO reset of the RFDC. It consumes the start_nco_reset pulse and sysref_wait_cycles value produced by the RFDC timing-control register block. It returns nco_reset_done and nco_sync_failed to that same block for readback. The block lives in the clk[0] (DB0 radio clock) domain and drives the NCO reset and update-request signals toward the RFDC tiles.

Parameters:
TIMEOUT_CYCLES, 65536, clk cycles allowed between expected events (SYSREF or update ack) before declaring sync failure; must be >= 2.

Ports:
clk  in  1  DB0 radio clock; the only clock.
rst  in  1  synchronous, active-high reset.
start_nco_reset  in  1  single-cycle start request.
sysref_wait_cycles  in  8  number of additional SYSREF periods to hold the NCO reset; latched at start.
sysref_pulse  in  1  single-cycle SYSREF edge indication, already in the clk domain.
nco_reset  out  1  level; holds the RFDC NCOs in reset while high.
nco_update_req  out  1  single-cycle request for the RFDC to apply the NCO update.
nco_update_ack  in  1  single-cycle acknowledge from the RFDC.
nco_reset_done  out  1  sticky; the sequence has finished (success or failure).
nco_sync_failed  out  1  sticky; the sequence ended on a timeout.
busy  out  1  high in every state except IDLE and DONE.

Behaviour:
- Reset values: nco_reset=0, nco_update_req=0, nco_reset_done=0, nco_sync_failed=0, busy=0. State=IDLE, counters=0.
- States: IDLE, ARM, HOLD, UPDATE, WAIT_ACK, DONE. All transitions are registered, with one-cycle latency.
- IDLE/DONE + start_nco_reset:
  - Latch sysref_wait_cycles into wait_q.
  - Clear nco_reset_done and nco_sync_failed.
  - Clear the timeout counter.
  - Go to ARM.
  - A sysref_pulse in the same cycle as start is ignored and not counted.
- ARM: wait for the first sysref_pulse. When sysref_pulse arrives at cycle t, nco_reset=1 from t+1, sp_cnt=0, state=HOLD.
- HOLD: on each sysref_pulse:
  - If sp_cnt==wait_q: nco_reset=0 on the next cycle and go to UPDATE.
  - Otherwise sp_cnt++.
  - Net effect: nco_reset is high for exactly wait_q+1 SYSREF periods, and both edges are one cycle after a SYSREF pulse.
- UPDATE: nco_update_req=1 for exactly one cycle, then go to WAIT_ACK.
- WAIT_ACK: on nco_update_ack, go to DONE and set nco_reset_done=1. An ack seen in any other state is ignored.
- DONE: hold nco_reset_done and nco_sync_failed until the next start or rst.
- Timeout counter:
  - Counts clk cycles in ARM, HOLD and WAIT_ACK.
  - Cleared on state entry and on each sysref_pulse in ARM or HOLD.
  - Counter width is clog2(TIMEOUT_CYCLES); it saturates and never wraps.
  - When it reaches TIMEOUT_CYCLES-1 without the expected event, the next cycle gives: nco_reset=0, nco_sync_failed=1, nco_reset_done=1, state=DONE.
  - If the expected event and the terminal count occur in the same cycle, the event wins.
- start_nco_reset while busy=1: ignored, with no state change and no re-latch.
- sysref_wait_cycles changes after start: no effect until the next start.
- rst mid-sequence: all outputs return to their reset values on the next edge, including dropping nco_reset immediately. No update request is issued.
- nco_reset and nco_update_req are never high in the same cycle.

Test Plan:
- wait=0: start, then SYSREF every 20 cycles starting at cycle 10.
  - nco_reset is high from cycle 11 to cycle 30 inclusive (low at 31).
  - nco_update_req pulses at cycle 32.
  - An ack at cycle 35 gives nco_reset_done=1 at 36 and nco_sync_failed=0.
- wait=3, SYSREF period 20:
  - nco_reset is high for exactly 80 cycles.
  - nco_update_req is a single cycle.
  - done is set only after the ack.
- TIMEOUT_CYCLES=100 with no SYSREF after start: after 100 cycles in ARM, nco_sync_failed=1, nco_reset_done=1, nco_reset=0 throughout.
- TIMEOUT_CYCLES=100 with SYSREF present but no ack: failure is flagged 100 cycles after entering WAIT_ACK, and no second nco_update_req is issued.
- Second start while busy, plus sysref_wait_cycles changed 5→1 mid-sequence: the original wait=5 hold length (6 periods) is kept, and only one done is produced.
- rst asserted during HOLD:
  - nco_reset drops the next cycle and all flags clear.
  - A later start with wait=0 completes normally.
  - A new start from DONE clears a prior failed flag on the cycle after start.
